mem_writeback: RTL and testbench

//  Memory-access / write-back stage of the SIMPLE pipeline. Accepts one executed

---
 rtl/mem_writeback.sv | 179 +++++++++++++++++
 tb/tb_mem_writeback.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// Memory-access / write-back stage: retires ALU ops directly, runs loads and stores
// over a req/ack bus with a wait-state timeout, and drives the register-file write bus.
module mem_writeback #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [15:0] ex_result,
    input  logic        ex_writereg,
    input  logic [2:0]  ex_regaddress,
    input  logic [1:0]  ex_memwrite,
    input  logic [15:0] ex_address,
    input  logic [15:0] ex_storedata,
    input  logic        ex_halt,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        writeflag,
    output logic [2:0]  writetarget,
    output logic [15:0] aluwriteval,
    output logic [15:0] readoutwriteval,
    output logic        readoutSelect,
    output logic        bus_error,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  pend_reg_q, pend_reg_d;
    logic        pend_wr_q, pend_wr_d;
    logic [7:0]  wait_q, wait_d;
    logic        writeflag_q, writeflag_d;
    logic [2:0]  writetarget_q, writetarget_d;
    logic [15:0] aluwriteval_q, aluwriteval_d;
    logic [15:0] readoutwriteval_q, readoutwriteval_d;
    logic        readout_sel_q, readout_sel_d;
    logic        bus_error_q, bus_error_d;
    logic        halted_q, halted_d;

    logic is_mem_op;
    assign is_mem_op = (ex_memwrite == 2'b01) || (ex_memwrite == 2'b10);

    always_comb begin
        state_d           = state_q;
        mem_req_d         = mem_req_q;
        mem_we_d          = mem_we_q;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        pend_reg_d        = pend_reg_q;
        pend_wr_d         = pend_wr_q;
        wait_d            = wait_q;
        writeflag_d       = 1'b0;
        writetarget_d     = writetarget_q;
        aluwriteval_d     = aluwriteval_q;
        readoutwriteval_d = readoutwriteval_q;
        readout_sel_d     = readout_sel_q;
        bus_error_d       = bus_error_q;
        halted_d          = halted_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (is_mem_op) begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ex_memwrite == 2'b10);
                        mem_addr_d  = ex_address;
                        mem_wdata_d = ex_storedata;
                        pend_reg_d  = ex_regaddress;
                        pend_wr_d   = ex_writereg;
                        wait_d      = 8'd0;
                    end else if (ex_writereg) begin
                        // Write-back values only move on a write so they hold otherwise.
                        writeflag_d   = 1'b1;
                        writetarget_d = ex_regaddress;
                        aluwriteval_d = ex_result;
                        readout_sel_d = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    wait_d    = 8'd0;
                    if (!mem_we_q && pend_wr_q) begin
                        writeflag_d       = 1'b1;
                        writetarget_d     = pend_reg_q;
                        readoutwriteval_d = mem_rdata;
                        readout_sel_d     = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    wait_d      = 8'd0;
                    bus_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= 16'd0;
            mem_wdata_q       <= 16'd0;
            pend_reg_q        <= 3'd0;
            pend_wr_q         <= 1'b0;
            wait_q            <= 8'd0;
            writeflag_q       <= 1'b0;
            writetarget_q     <= 3'd0;
            aluwriteval_q     <= 16'd0;
            readoutwriteval_q <= 16'd0;
            readout_sel_q     <= 1'b0;
            bus_error_q       <= 1'b0;
            halted_q          <= 1'b0;
        end else begin
            state_q           <= state_d;
            mem_req_q         <= mem_req_d;
            mem_we_q          <= mem_we_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            pend_reg_q        <= pend_reg_d;
            pend_wr_q         <= pend_wr_d;
            wait_q            <= wait_d;
            writeflag_q       <= writeflag_d;
            writetarget_q     <= writetarget_d;
            aluwriteval_q     <= aluwriteval_d;
            readoutwriteval_q <= readoutwriteval_d;
            readout_sel_q     <= readout_sel_d;
            bus_error_q       <= bus_error_d;
            halted_q          <= halted_d;
        end
    end

    // Gated by reset so every output, ex_ready included, reads 0 while reset is held.
    assign ex_ready        = reset & (state_q == IDLE);
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign writeflag       = writeflag_q;
    assign writetarget     = writetarget_q;
    assign aluwriteval     = aluwriteval_q;
    assign readoutwriteval = readoutwriteval_q;
    assign readoutSelect   = readout_sel_q;
    assign bus_error       = bus_error_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: a scoreboard queue of expected write-backs checked by a
// monitor, plus a configurable memory responder with programmable wait states.
module tb_mem_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [15:0] ex_result = 16'd0;
    logic        ex_writereg = 1'b0;
    logic [2:0]  ex_regaddress = 3'd0;
    logic [1:0]  ex_memwrite = 2'b00;
    logic [15:0] ex_address = 16'd0;
    logic [15:0] ex_storedata = 16'd0;
    logic        ex_halt = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ack = 1'b0;
    logic        writeflag;
    logic [2:0]  writetarget;
    logic [15:0] aluwriteval;
    logic [15:0] readoutwriteval;
    logic        readoutSelect;
    logic        bus_error;
    logic        halted;

    typedef struct {
        logic [2:0]  tgt;
        logic        sel;
        logic [15:0] val;
    } wb_t;

    wb_t exp_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  mem_wait_cfg = 0;       // -1: never acknowledge
    logic [15:0] mem_rdata_cfg = 16'd0;
    int  req_cnt = 0;

    mem_writeback #(.TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_writereg(ex_writereg),
        .ex_regaddress(ex_regaddress), .ex_memwrite(ex_memwrite),
        .ex_address(ex_address), .ex_storedata(ex_storedata), .ex_halt(ex_halt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .writeflag(writeflag), .writetarget(writetarget),
        .aluwriteval(aluwriteval), .readoutwriteval(readoutwriteval),
        .readoutSelect(readoutSelect), .bus_error(bus_error), .halted(halted)
    );

    always #5 clock = ~clock;

    // Memory responder: acks in the (mem_wait_cfg+1)-th request cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_req) begin
                if (mem_wait_cfg >= 0 && req_cnt == mem_wait_cfg) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_rdata_cfg;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'hDEAD;
                end
                req_cnt++;
            end else begin
                mem_ack = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Write-back monitor: every writeflag cycle must match the scoreboard head.
    initial begin
        wb_t e;
        logic [15:0] got;
        forever begin
            @(negedge clock);
            if (writeflag === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL wb_unexpected: got target=%0d sel=%0b alu=%h rd=%h, required no write-back",
                             writetarget, readoutSelect, aluwriteval, readoutwriteval);
                end else begin
                    e = exp_q.pop_front();
                    got = readoutSelect ? readoutwriteval : aluwriteval;
                    if (writetarget !== e.tgt || readoutSelect !== e.sel || got !== e.val)
                        $display("FAIL wb_value: got target=%0d sel=%0b val=%h, required target=%0d sel=%0b val=%h",
                                 writetarget, readoutSelect, got, e.tgt, e.sel, e.val);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    // Presents one op (caller aligned #1 after posedge); returns #1 after the accepting edge.
    task automatic issue(input logic [15:0] res, input logic wr, input logic [2:0] rd,
                         input logic [1:0] mw, input logic [15:0] addr,
                         input logic [15:0] sd, input logic hlt);
        logic rdy;
        bit   done;
        ex_valid = 1'b1; ex_result = res; ex_writereg = wr; ex_regaddress = rd;
        ex_memwrite = mw; ex_address = addr; ex_storedata = sd; ex_halt = hlt;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            rdy = ex_ready;
            @(posedge clock);
            #1;
            if (rdy === 1'b1) done = 1;
        end
        ex_valid = 1'b0;
        $display("issue res=%h wr=%0b rd=%0d mw=%b addr=%h sd=%h hlt=%0b accepted=%0b",
                 res, wr, rd, mw, addr, sd, hlt, done);
        if (!done) begin
            total_cnt++;
            $display("FAIL issue_timeout: got no acceptance in 50 cycles, required acceptance");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++;
        if ({ex_ready, mem_req, mem_we, writeflag, readoutSelect, bus_error, halted} !== 7'd0 ||
            {mem_addr, mem_wdata, aluwriteval, readoutwriteval} !== 64'd0 || writetarget !== 3'd0)
            $display("FAIL reset_outputs: got rdy=%b req=%b wf=%b err=%b halt=%b alu=%h, required all 0",
                     ex_ready, mem_req, writeflag, bus_error, halted, aluwriteval);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total_cnt++;
        if (ex_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ex_ready);
        else pass_cnt++;
    endtask

    task automatic test_alu();
        exp_q.push_back('{3'd3, 1'b0, 16'h1234});
        issue(16'h1234, 1'b1, 3'd3, 2'b00, 16'h0, 16'h0, 1'b0);
        total_cnt++;
        if (writeflag !== 1'b1 || writetarget !== 3'd3 || aluwriteval !== 16'h1234 || readoutSelect !== 1'b0)
            $display("FAIL alu_latency: got wf=%b tgt=%0d alu=%h sel=%b, required 1 3 1234 0",
                     writeflag, writetarget, aluwriteval, readoutSelect);
        else pass_cnt++;
        // Non-writing op and memwrite=11 behave as plain ALU ops.
        issue(16'h7777, 1'b0, 3'd6, 2'b00, 16'h0, 16'h0, 1'b0);
        total_cnt++;
        if (writeflag !== 1'b0 || aluwriteval !== 16'h1234)
            $display("FAIL alu_nowrite_hold: got wf=%b alu=%h, required 0 1234", writeflag, aluwriteval);
        else pass_cnt++;
        exp_q.push_back('{3'd0, 1'b0, 16'hFFFF});
        issue(16'hFFFF, 1'b1, 3'd0, 2'b11, 16'h0020, 16'h0, 1'b0);
        total_cnt++;
        if (mem_req !== 1'b0 || ex_ready !== 1'b1)
            $display("FAIL alu_mw11: got req=%b rdy=%b, required 0 1", mem_req, ex_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int wcnt = 0;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] v;
            v = 16'h1000 + 16'(i * 16'h0111);
            exp_q.push_back('{3'(i + 1), 1'b0, v});
            issue(v, 1'b1, 3'(i + 1), 2'b00, 16'h0, 16'h0, 1'b0);
            if (writeflag === 1'b1) wcnt++;
        end
        @(posedge clock);
        #1;
        total_cnt++;
        if (wcnt != 3 || writeflag !== 1'b0 || aluwriteval !== 16'h1222 || writetarget !== 3'd3)
            $display("FAIL b2b: got writes=%0d wf=%b alu=%h tgt=%0d, required 3 0 1222 3",
                     wcnt, writeflag, aluwriteval, writetarget);
        else pass_cnt++;
    endtask

    task automatic test_load();
        int low = 0;
        int addr_bad = 0;
        mem_wait_cfg  = 3;
        mem_rdata_cfg = 16'hBEEF;
        exp_q.push_back('{3'd5, 1'b1, 16'hBEEF});
        issue(16'h0, 1'b1, 3'd5, 2'b01, 16'h0040, 16'h0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ex_ready === 1'b1) break;
            low++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040 || writeflag !== 1'b0)
                addr_bad++;
        end
        @(posedge clock);
        #1;
        total_cnt++;
        if (low != 4) $display("FAIL load_ready_low: got %0d cycles, required 4", low);
        else pass_cnt++;
        total_cnt++;
        if (addr_bad != 0) $display("FAIL load_bus: got %0d bad req cycles, required 0", addr_bad);
        else pass_cnt++;
    endtask

    task automatic test_store();
        int reqs = 0;
        int bad = 0;
        mem_wait_cfg = 0;
        issue(16'h0, 1'b1, 3'd4, 2'b10, 16'h0010, 16'h00AA, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ex_ready === 1'b1) break;
            if (mem_req === 1'b1) begin
                reqs++;
                if (mem_we !== 1'b1 || mem_wdata !== 16'h00AA || mem_addr !== 16'h0010) bad++;
            end
        end
        repeat (2) @(posedge clock);
        #1;
        total_cnt++;
        if (reqs != 1 || bad != 0)
            $display("FAIL store_bus: got req cycles=%0d bad=%0d, required 1 0", reqs, bad);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int reqs = 0;
        mem_wait_cfg = -1;
        issue(16'h0, 1'b1, 3'd2, 2'b01, 16'h0080, 16'h0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (mem_req !== 1'b1) break;
            reqs++;
        end
        total_cnt++;
        if (reqs != 15) $display("FAIL timeout_cycles: got %0d, required 15", reqs);
        else pass_cnt++;
        total_cnt++;
        if (bus_error !== 1'b1 || ex_ready !== 1'b1)
            $display("FAIL timeout_flags: got err=%b rdy=%b, required 1 1", bus_error, ex_ready);
        else pass_cnt++;
        @(posedge clock);
        #1;
        exp_q.push_back('{3'd1, 1'b0, 16'h5555});
        issue(16'h5555, 1'b1, 3'd1, 2'b00, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_halt();
        int bad = 0;
        issue(16'h9999, 1'b1, 3'd7, 2'b01, 16'h0100, 16'h0, 1'b1);
        total_cnt++;
        if (halted !== 1'b1 || ex_ready !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL halt_state: got halted=%b rdy=%b req=%b, required 1 0 0", halted, ex_ready, mem_req);
        else pass_cnt++;
        ex_valid = 1'b1; ex_halt = 1'b0; ex_memwrite = 2'b00;
        ex_writereg = 1'b1; ex_regaddress = 3'd6; ex_result = 16'hABCD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ex_ready !== 1'b0 || halted !== 1'b1) bad++;
        end
        @(posedge clock);
        #1;
        ex_valid = 1'b0;
        total_cnt++;
        if (bad != 0 || aluwriteval === 16'hABCD)
            $display("FAIL halt_blocks: got bad=%0d alu=%h, required 0 and no ABCD", bad, aluwriteval);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        mem_wait_cfg = -1;
        issue(16'h0, 1'b1, 3'd4, 2'b01, 16'h0200, 16'h0, 1'b0);
        repeat (2) @(negedge clock);
        total_cnt++;
        if (mem_req !== 1'b1) $display("FAIL mid_pre_req: got %b, required 1", mem_req);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (mem_req !== 1'b0 || writeflag !== 1'b0 || halted !== 1'b0 || bus_error !== 1'b0 ||
            ex_ready !== 1'b0 || mem_addr !== 16'd0)
            $display("FAIL mid_reset: got req=%b wf=%b halt=%b err=%b rdy=%b addr=%h, required all 0",
                     mem_req, writeflag, halted, bus_error, ex_ready, mem_addr);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total_cnt++;
        if (ex_ready !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL mid_release: got rdy=%b req=%b, required 1 0", ex_ready, mem_req);
        else pass_cnt++;
        exp_q.push_back('{3'd2, 1'b0, 16'h0F0F});
        issue(16'h0F0F, 1'b1, 3'd2, 2'b00, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_halt();
        test_reset_mid_access();
        repeat (3) @(posedge clock);
        #1;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
